mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port program/data RAM between the CPU memory port and a DMA/debug loader port.
//  Sits between the processor core's memory interface and the ram instance; serialises accesses
//  with a req/ack handshake, supports DMA burst locking, and returns read data per requester.
// PARAMETERS
//  DATA_WIDTH  8  RAM word width
//  ADDR_WIDTH  8  RAM address width
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst         in   1   synchronous reset, active-low
//  cpu_req     in   1   CPU access request; held with cpu_wr/addr/wdata stable until cpu_ack
//  cpu_wr      in   1   1 = write, 0 = read
//  cpu_addr    in   AW  CPU address
//  cpu_wdata   in   DW  CPU write data
//  cpu_ack     out  1   one-cycle completion pulse
//  cpu_rdata   out  DW  read data, valid from cpu_ack until next CPU read completes
//  dma_req     in   1   DMA access request, same handshake as CPU
//  dma_lock    in   1   hold RAM ownership for DMA between transactions (burst)
//  dma_wr      in   1   1 = write, 0 = read
//  dma_addr    in   AW  DMA address
//  dma_wdata   in   DW  DMA write data
//  dma_ack     out  1   one-cycle completion pulse
//  dma_rdata   out  DW  read data, valid from dma_ack until next DMA read completes
//  ram_wr_en   out  1   RAM write enable
//  ram_addr    out  AW  RAM address
//  ram_w_data  out  DW  RAM write data
//  ram_r_data  in   DW  RAM read data (combinational read)
//  owner       out  1   0 = CPU, 1 = DMA; current/last grant
//  busy        out  1   high in ACCESS and RESP
// BEHAVIOUR
//  - Reset (rst=0 at edge): state IDLE; all outputs 0; rdata regs 0; lock cleared; RR pointer -> CPU.
//  - States: IDLE, ACCESS, RESP.
//  - IDLE: when any eligible req=1, pick winner; latch wr/addr/wdata; set owner -> ACCESS.
//  - ACCESS (1 cycle): ram_addr/ram_w_data from latch; ram_wr_en = latched wr. Edge at end of
//    ACCESS commits the write, or captures ram_r_data into the winner's rdata reg. -> RESP.
//  - RESP (1 cycle): winner's ack = 1; ram_wr_en = 0. The acked requester's req is ignored this
//    cycle. If the other requester is eligible with req=1 -> latch it, ACCESS; else -> IDLE.
//  - Latency: req seen in IDLE at cycle t -> ACCESS t+1 -> ack at t+2. Back-to-back alternate
//    grants every 2 cycles; same-port repeat every 3 cycles (via IDLE).
//  - Lock: if dma_lock=1 at the end of a DMA RESP, CPU becomes ineligible until dma_lock=0
//    is sampled in IDLE. dma_lock alone never starts a transaction.
//  - Eligibility: CPU ineligible while lock held; DMA always eligible.
//  - Simultaneous cpu_req & dma_req in IDLE: resolved per CONFIGURATION.
//  - Reset mid-ACCESS: a write in flight is not committed if rst=0 at that edge; no ack is issued.
//  - Requester dropping req before ack: protocol violation. The transaction still completes and
//    acks (no abort).
//  - ram_* outputs are 0 in IDLE and RESP. Addresses pass through unmodified (no wrap logic).
// CONFIGURATION
//  ARB_RR_EN defined: round-robin. On a tie, grant the port not served last. Pointer updates on
//    each grant.
//  ARB_RR_EN undefined: fixed priority, CPU > DMA on a tie. Lock still overrides.
// STRUCTURE
//  - Package pdua_arb_pkg:
//    - state encoding localparams ST_IDLE/ST_ACCESS/ST_RESP (2-bit)
//    - OWN_CPU=0, OWN_DMA=1
//  - Sub-module arb_pick: combinational winner select.
//    - Inputs: reqs, eligibility, last-owner pointer.
//    - Output: grant_valid, grant_id.
//  - Top keeps FSM, latches, rdata regs and lock flag.
// TESTING
//  1. Reset: hold rst=0 2 cycles with reqs high -> all outputs 0, no ack; release -> first grant
//     follows 1 cycle later.
//  2. CPU write 0x5A @0x10, then CPU read @0x10 -> ram_wr_en high only in ACCESS; cpu_ack at t+2;
//     cpu_rdata=0x5A.
//  3. cpu_req & dma_req raised same cycle, held. Without ARB_RR_EN: CPU acked, then DMA 2 cycles
//     later. With ARB_RR_EN: grants alternate over 4 transactions.
//  4. DMA burst: dma_lock=1, 4 DMA writes 0x20..0x23 while cpu_req=1 -> CPU waits.
//     Drop lock -> CPU acked within 3 cycles.
//  5. rst=0 asserted during ACCESS of DMA write 0xFF @0x30 -> RAM @0x30 unchanged; no dma_ack;
//     state IDLE.
//  6. Random req/wr/addr mix, 1000 txns vs reference RAM model -> every rdata matches; one ack
//     per accepted req.

Source files
------------

// File: rtl/pdua_arb_pkg.sv
// Shared types for the program/data RAM port arbiter: FSM state encoding and
// owner identifiers used by mem_port_arbiter and arb_pick.
package pdua_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between the CPU (bit 0) and DMA (bit 1) ports.
// Define ARB_RR_EN for round-robin tie-break; otherwise CPU wins ties.
module arb_pick
  import pdua_arb_pkg::*;
(
  input  logic [1:0] reqs,
  input  logic [1:0] elig,
  input  logic       last_owner,
  output logic       grant_valid,
  output logic       grant_id
);

  logic [1:0] cand;

`ifdef ARB_RR_EN
  logic tie_winner;
  assign tie_winner = ~last_owner;
`else
  logic tie_winner;
  logic unused_last_owner;
  assign tie_winner        = OWN_CPU;
  assign unused_last_owner = last_owner;
`endif

  always_comb begin
    cand        = reqs & elig;
    grant_valid = |cand;
    grant_id    = OWN_CPU;
    if (cand == 2'b11) begin
      grant_id = tie_winner;
    end else if (cand[1]) begin
      grant_id = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the CPU port and a DMA/debug loader port,
// with DMA burst locking. Define ARB_RR_EN for round-robin tie-break (default: CPU priority).
module mem_port_arbiter
  import pdua_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_lock,
  input  logic                  dma_wr,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  input  logic [DATA_WIDTH-1:0] ram_r_data,
  output logic                  owner,
  output logic                  busy
);

  // Handshake: a port raises req with wr/addr/wdata stable and holds them until
  // its one-cycle ack; the transaction is accepted on the grant edge and is never
  // aborted, so dropping req early still yields an ack.

  state_t                  state, state_nxt;
  logic                    lock_q, lock_nxt;
  logic                    lat_wr;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic [1:0]              pick_reqs, pick_elig;
  logic                    grant_valid, grant_id;

  arb_pick u_pick (
    .reqs        (pick_reqs),
    .elig        (pick_elig),
    .last_owner  (owner),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // In RESP only the port that was not just served may be granted; a DMA RESP
  // with dma_lock high locks the CPU out on that very edge.
  always_comb begin
    pick_reqs = 2'b00;
    lock_nxt  = lock_q;
    case (state)
      ST_IDLE: begin
        pick_reqs = {dma_req, cpu_req};
        lock_nxt  = lock_q & dma_lock;
      end
      ST_RESP: begin
        if (owner == OWN_DMA) begin
          pick_reqs = {1'b0, cpu_req};
          lock_nxt  = lock_q | dma_lock;
        end else begin
          pick_reqs = {dma_req, 1'b0};
        end
      end
      default: ;
    endcase
    pick_elig = {1'b1, ~lock_nxt};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = grant_valid ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = grant_valid ? ST_ACCESS : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_CPU;
      lock_q    <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      state  <= state_nxt;
      lock_q <= lock_nxt;
      if (grant_valid) begin
        owner <= grant_id;
        if (grant_id == OWN_DMA) begin
          lat_wr    <= dma_wr;
          lat_addr  <= dma_addr;
          lat_wdata <= dma_wdata;
        end else begin
          lat_wr    <= cpu_wr;
          lat_addr  <= cpu_addr;
          lat_wdata <= cpu_wdata;
        end
      end
      if (state == ST_ACCESS && !lat_wr) begin
        if (owner == OWN_DMA) dma_rdata <= ram_r_data;
        else                  cpu_rdata <= ram_r_data;
      end
    end
  end

  // Write enable is masked by reset so a write in flight is not committed on a reset edge.
  always_comb begin
    busy       = (state != ST_IDLE);
    cpu_ack    = (state == ST_RESP) && (owner == OWN_CPU);
    dma_ack    = (state == ST_RESP) && (owner == OWN_DMA);
    ram_wr_en  = 1'b0;
    ram_addr   = '0;
    ram_w_data = '0;
    if (state == ST_ACCESS) begin
      ram_wr_en  = lat_wr & rst;
      ram_addr   = lat_addr;
      ram_w_data = lat_wdata;
    end
  end

endmodule
